led_dimmer: RTL

Output stage placed directly downstream of the LED register peripheral: consumes the 8-bit LED pattern it drives and produces the physical LED pins. Adds global PWM brightness control and optional blinking, configured through a small memory-mapped register file with the same write-enable/address/data/registered-read port style as the other peripherals. Sits between the peripheral's `led` output and the board LED pins.

---
 rtl/led_dimmer_pkg.sv | 30 +++
 rtl/led_dimmer_if.sv | 13 +
 rtl/led_dimmer_pwm_timer.sv | 29 ++
 rtl/led_dimmer.sv | 89 ++++++++
 4 files changed

// File: rtl/led_dimmer_pkg.sv
// Shared constants for the LED dimmer: register map, CTRL layout and reset values.
package led_pkg;

    localparam logic [1:0] LED_CTRL = 2'd0;
    localparam logic [1:0] LED_DUTY = 2'd1;
    localparam logic [1:0] LED_BDIV = 2'd2;
    localparam logic [1:0] LED_STAT = 2'd3;

    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_BLINK_BIT = 1;

    localparam logic [7:0]  DUTY_RST = 8'hFF;
    localparam logic [15:0] BDIV_RST = 16'h00F9;

    // Field order puts blink_en at bit1 and enable at bit0, matching the CTRL register.
    typedef struct packed {
        logic blink_en;
        logic enable;
    } ctrl_t;

    localparam ctrl_t CTRL_RST = '{blink_en: 1'b0, enable: 1'b1};

    // Full-scale and zero duty are pinned so 0xFF means always on.
    function automatic logic pwm_level(input logic [7:0] duty, input logic [7:0] cnt);
        if (duty == 8'hFF) return 1'b1;
        if (duty == 8'h00) return 1'b0;
        return cnt < duty;
    endfunction

endpackage

// File: rtl/led_dimmer_if.sv
// Register port and LED pattern/pin bundle for the LED dimmer.
// Protocol: a write happens on every rising edge with wea=1; douta returns register[addra] one cycle later.
interface led_dimmer_if;
    logic        wea;
    logic [1:0]  addra;
    logic [31:0] dina;
    logic [31:0] douta;
    logic [7:0]  led_in;
    logic [7:0]  led_out;

    modport master (output wea, addra, dina, led_in, input douta, led_out);
    modport slave  (input wea, addra, dina, led_in, output douta, led_out);
endinterface

// File: rtl/led_dimmer_pwm_timer.sv
// PWM timebase: prescaler producing tick, and the 8-bit PWM phase counter.
module led_pwm_timer #(
    parameter int PRESCALE = 196
) (
    input  logic       clk,
    input  logic       rst,
    output logic       tick,
    output logic       period_end,
    output logic [7:0] pwm_cnt
);

    localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);

    logic [15:0] presc;

    assign tick       = (presc == PRESC_LAST);
    assign period_end = tick && (pwm_cnt == 8'hFF);

    always_ff @(posedge clk) begin
        if (rst) begin
            presc   <= '0;
            pwm_cnt <= '0;
        end else begin
            presc <= tick ? 16'd0 : presc + 16'd1;
            if (tick) pwm_cnt <= pwm_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/led_dimmer.sv
// LED output stage: register file, blink generator and PWM gating of the LED pattern.
module led_dimmer
    import led_pkg::*;
#(
    parameter int PRESCALE = 196
) (
    input  logic         clk,
    input  logic         rst,
    led_dimmer_if.slave  bus
);

    ctrl_t       ctrl;
    logic [7:0]  duty;
    logic [15:0] bdiv;
    logic [15:0] blink_cnt;
    logic        blink_phase;
    logic [7:0]  led_q;
    logic [31:0] dout_q;
    logic [31:0] rd_data;

    logic        tick;
    logic        period_end;
    logic [7:0]  pwm_cnt;
    logic        blink_adv;
    logic        wr_ctrl;
    logic        blink_arm;
    logic        led_gate;

    led_pwm_timer #(.PRESCALE(PRESCALE)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .period_end (period_end),
        .pwm_cnt    (pwm_cnt)
    );

    // period_end only ever fires on a tick; qualifying keeps the two strobes coherent.
    assign blink_adv = tick && period_end;
    assign wr_ctrl   = bus.wea && (bus.addra == LED_CTRL);
    assign blink_arm = wr_ctrl && bus.dina[CTRL_BLINK_BIT] && !ctrl.blink_en;
    assign led_gate  = ctrl.enable && pwm_level(duty, pwm_cnt) &&
                       (!ctrl.blink_en || blink_phase);

    always_comb begin
        rd_data = '0;
        case (bus.addra)
            LED_CTRL: rd_data = {30'd0, ctrl};
            LED_DUTY: rd_data = {24'd0, duty};
            LED_BDIV: rd_data = {16'd0, bdiv};
            default:  rd_data = {16'd0, pwm_cnt, 7'd0, blink_phase};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl        <= CTRL_RST;
            duty        <= DUTY_RST;
            bdiv        <= BDIV_RST;
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
            led_q       <= '0;
            dout_q      <= '0;
        end else begin
            if (wr_ctrl) ctrl <= ctrl_t'(bus.dina[1:0]);
            if (bus.wea && bus.addra == LED_DUTY) duty <= bus.dina[7:0];
            if (bus.wea && bus.addra == LED_BDIV) bdiv <= bus.dina[15:0];

            // Arming blink restarts the on-phase; otherwise the counter steps once per PWM period.
            if (blink_arm) begin
                blink_cnt   <= '0;
                blink_phase <= 1'b1;
            end else if (blink_adv) begin
                if (blink_cnt >= bdiv) begin
                    blink_cnt   <= '0;
                    blink_phase <= !blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + 16'd1;
                end
            end

            led_q  <= bus.led_in & {8{led_gate}};
            dout_q <= rd_data;
        end
    end

    assign bus.led_out = led_q;
    assign bus.douta   = dout_q;

endmodule
